// File: rtl/pmod_i2c_sequencer.sv
// pmod_i2c_sequencer: polls a PWM LED driver and a jack-detect expander through an I2C byte core.
// Define PMOD_I2C_RETRY_EN to retry a NACKed transaction up to three attempts before flagging err.
module pmod_i2c_sequencer #(
  parameter int N_LEDS = 8,
  parameter logic [6:0] LED_ADDR = 7'h5C,
  parameter logic [6:0] JACK_ADDR = 7'h18,
  parameter int POLL_DIV = 131072
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8*N_LEDS-1:0] led,
  output logic [1:0]          cmd,
  output logic                stb,
  output logic [7:0]          data_in,
  output logic                ack_in,
  input  logic                ready,
  input  logic [7:0]          data_out,
  input  logic                ack_out,
  output logic [7:0]          jack,
  output logic                jack_valid,
  output logic                jack_changed,
  output logic                err,
  input  logic                err_clr
);
`ifdef PMOD_I2C_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int CW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_DIV - 1);
  localparam logic [4:0] LED_LAST = 5'(3 + 2 * N_LEDS);
  localparam logic [4:0] JACK_LAST = 5'd6;
  localparam logic [1:0] C_START = 2'b00, C_STOP = 2'b01, C_WRITE = 2'b10, C_READ = 2'b11;

  typedef enum logic [1:0] {S_WAIT, S_LED, S_JACK} state_t;

  state_t              r_state, w_state, w_xs;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [4:0]          r_step, w_step, w_last, w_pidx;
  logic [1:0]          r_attempt, w_attempt;
  logic                r_busy, w_busy, r_retry, w_retry;
  logic [8*N_LEDS-1:0] r_snap, w_snap;
  logic                r_stb, w_stb;
  logic [1:0]          r_cmd, w_cmd, w_scmd;
  logic [7:0]          r_data, w_data, w_sdata, w_lvl, w_pwm;
  logic [7:0]          r_jack, w_jack;
  logic                r_jv, w_jv, r_jc, w_jc, r_err, w_err;
  logic                w_issue, w_done, w_nack;

  // PWM bytes pair up per channel: even byte drives the negative half, odd byte the positive half
  always_comb begin
    w_pidx = r_step - 5'd3;
    w_lvl = '0;
    for (int i = 0; i < N_LEDS; i++)
      if (w_pidx[4:1] == 4'(i)) w_lvl = r_snap[8*i +: 8];
    w_pwm = w_pidx[0] ? ((!w_lvl[7] && |w_lvl) ? w_lvl : 8'h00)
                      : (w_lvl[7] ? 8'(~w_lvl + 8'd1) : 8'h00);
  end

  always_comb begin
    w_xs = (r_state == S_WAIT) ? S_LED : r_state;
    w_last = (w_xs == S_LED) ? LED_LAST : JACK_LAST;
    if (w_xs == S_LED) begin
      w_scmd = (r_step == 5'd0) ? C_START : (r_step == LED_LAST) ? C_STOP : C_WRITE;
      w_sdata = (r_step == 5'd1) ? {LED_ADDR, 1'b0} : (r_step == 5'd2) ? 8'h82 : w_pwm;
    end else begin
      w_scmd = (r_step == 5'd0 || r_step == 5'd3) ? C_START
             : (r_step == 5'd5) ? C_READ : (r_step == JACK_LAST) ? C_STOP : C_WRITE;
      w_sdata = (r_step == 5'd1) ? {JACK_ADDR, 1'b0} : (r_step == 5'd4) ? {JACK_ADDR, 1'b1} : 8'h00;
    end
  end

  // The START of a round may issue on the last WAIT cycle so polling stays exactly POLL_DIV apart
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_step = r_step;
    w_attempt = r_attempt;
    w_busy = r_busy;
    w_retry = r_retry;
    w_snap = r_snap;
    w_stb = 1'b0;
    w_cmd = r_cmd;
    w_data = r_data;
    w_jack = r_jack;
    w_jv = 1'b0;
    w_jc = 1'b0;
    w_issue = (r_state != S_WAIT || r_cnt == CNT_LAST) && !r_busy && !r_stb && ready;
    w_done = r_busy && !r_stb && ready;
    w_nack = w_done && r_cmd == C_WRITE && ack_out;
    w_err = (w_nack && (!RETRY || r_attempt == 2'd2)) ? 1'b1 : err_clr ? 1'b0 : r_err;
    if (r_state == S_WAIT) begin
      w_cnt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        w_state = S_LED;
        w_snap = led;
      end
    end
    if (w_issue) begin
      w_stb = 1'b1;
      w_busy = 1'b1;
      w_cmd = w_scmd;
      w_data = w_sdata;
    end
    if (w_done) w_busy = 1'b0;
    if (w_nack) begin
      w_step = w_last;
      w_retry = RETRY && r_attempt != 2'd2;
    end else if (w_done && r_cmd == C_STOP) begin
      w_step = '0;
      w_retry = 1'b0;
      w_attempt = r_retry ? r_attempt + 2'd1 : 2'd0;
      if (!r_retry) w_state = (r_state == S_LED) ? S_JACK : S_WAIT;
    end else if (w_done) begin
      w_step = r_step + 5'd1;
      if (r_cmd == C_READ) begin
        w_jack = data_out;
        w_jv = 1'b1;
        w_jc = data_out != r_jack;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_cnt <= '0;
      r_step <= '0;
      r_attempt <= '0;
      r_busy <= 1'b0;
      r_retry <= 1'b0;
      r_snap <= '0;
      r_stb <= 1'b0;
      r_cmd <= C_START;
      r_data <= '0;
      r_jack <= '0;
      r_jv <= 1'b0;
      r_jc <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_step <= w_step;
      r_attempt <= w_attempt;
      r_busy <= w_busy;
      r_retry <= w_retry;
      r_snap <= w_snap;
      r_stb <= w_stb;
      r_cmd <= w_cmd;
      r_data <= w_data;
      r_jack <= w_jack;
      r_jv <= w_jv;
      r_jc <= w_jc;
      r_err <= w_err;
    end
  end

  assign stb = r_stb;
  assign cmd = r_cmd;
  assign data_in = r_data;
  assign ack_in = 1'b1;
  assign jack = r_jack;
  assign jack_valid = r_jv;
  assign jack_changed = r_jc;
  assign err = r_err;
endmodule

// File: tb/tb_pmod_i2c_sequencer.sv
// tb_pmod_i2c_sequencer: byte-core model plus a command-list reference for LED and jack polling rounds.
module tb_pmod_i2c_sequencer;
  localparam int N = 8;
  localparam int PD = 16;
  localparam logic [6:0] LA = 7'h5C;
  localparam logic [6:0] JA = 7'h18;
`ifdef PMOD_I2C_RETRY_EN
  localparam int MAXA = 3;
`else
  localparam int MAXA = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0, ready = 1'b1, ack_out = 1'b0;
  logic [8*N-1:0] led = '0;
  logic [7:0] data_out = '0;
  logic [1:0] cmd;
  logic stb, ack_in, jack_valid, jack_changed, err;
  logic [7:0] data_in, jack;

  typedef struct {logic [1:0] c; logic [7:0] d; int t;} ent_t;
  ent_t log_q[$];
  ent_t exp_q[$];

  int checks = 0, errors = 0, cyc = 0, bc = 0, nack_cnt = 0;
  int jv_cnt = 0, jc_cnt = 0, proto = 0, exp_jv = 0, exp_jc = 0, rel = 0;
  logic [7:0] jack_val = '0, prev_jack = '0;
  logic exp_err = 1'b0;
  bit pend = 0, prev_stb = 0, clr_with_nack = 0, fired = 0;

  pmod_i2c_sequencer #(.N_LEDS(N), .LED_ADDR(LA), .JACK_ADDR(JA), .POLL_DIV(PD)) dut (
    .clk(clk), .rst_n(rst_n), .led(led), .cmd(cmd), .stb(stb), .data_in(data_in),
    .ack_in(ack_in), .ready(ready), .data_out(data_out), .ack_out(ack_out), .jack(jack),
    .jack_valid(jack_valid), .jack_changed(jack_changed), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Byte core: each command holds ready low for four cycles, then reports ACK/NACK and read data
  always @(negedge clk) begin
    cyc++;
    if (fired) begin
      err_clr = 1'b0;
      fired = 0;
    end
    if (jack_valid) jv_cnt++;
    if (jack_changed) begin
      if (jack_valid) jc_cnt++;
      else proto++;
    end
    if (stb && (prev_stb || !ready)) proto++;
    prev_stb = stb;
    if (!rst_n) begin
      bc = 0;
      ready = 1'b1;
    end else if (bc > 0) begin
      bc--;
      if (bc == 0) begin
        ready = 1'b1;
        ack_out = pend;
        data_out = jack_val;
        if (pend && clr_with_nack) begin
          err_clr = 1'b1;
          fired = 1;
        end
      end
    end else if (stb && ready) begin
      log_q.push_back('{cmd, data_in, cyc});
      pend = cmd == 2'b10 && data_in == {LA, 1'b0} && nack_cnt > 0;
      if (pend) nack_cnt--;
      ready = 1'b0;
      bc = 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] d);
    exp_q.push_back('{c, d, 0});
  endtask

  task automatic build_led(input logic [8*N-1:0] s, input int nacks);
    int f;
    f = nacks < MAXA ? nacks : MAXA;
    for (int a = 0; a < f; a++) begin
      push(2'b00, 8'h00);
      push(2'b10, {LA, 1'b0});
      push(2'b01, 8'h00);
    end
    if (f < MAXA) begin
      push(2'b00, 8'h00);
      push(2'b10, {LA, 1'b0});
      push(2'b10, 8'h82);
      for (int ch = 0; ch < N; ch++) begin
        int v;
        v = int'($signed(s[8*ch +: 8]));
        push(2'b10, v < 0 ? 8'(-v) : 8'h00);
        push(2'b10, v > 0 ? 8'(v) : 8'h00);
      end
      push(2'b01, 8'h00);
    end else exp_err = 1'b1;
  endtask

  task automatic build_jack();
    push(2'b00, 8'h00);
    push(2'b10, {JA, 1'b0});
    push(2'b10, 8'h00);
    push(2'b00, 8'h00);
    push(2'b10, {JA, 1'b1});
    push(2'b11, 8'h00);
    push(2'b01, 8'h00);
  endtask

  task automatic wait_log(input int n, input string tag);
    int b;
    b = 0;
    while (log_q.size() < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk({tag, " command wait"}, 32'(log_q.size() >= n), 1);
  endtask

  task automatic round(input int nacks, input bit tchk, input string tag);
    logic [8*N-1:0] s;
    s = led;
    wait_log(1, tag);
    if (tchk && log_q.size() > 0) begin
      chk({tag, " first cmd"}, 32'(log_q[0].c), 0);
      chk({tag, " start delay"}, log_q[0].t - rel, PD);
    end
    led = {$urandom, $urandom};
    build_led(s, nacks);
    build_jack();
    wait_log(exp_q.size(), tag);
    repeat (12) @(negedge clk);
    chk({tag, " length"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s cmd[%0d]", tag, i), 32'(log_q[i].c), 32'(exp_q[i].c));
      if (exp_q[i].c == 2'b10) chk($sformatf("%s data[%0d]", tag, i), 32'(log_q[i].d), 32'(exp_q[i].d));
    end
    exp_jv++;
    if (jack_val != prev_jack) exp_jc++;
    prev_jack = jack_val;
    chk({tag, " jack"}, 32'(jack), 32'(prev_jack));
    chk({tag, " jack_valid count"}, jv_cnt, exp_jv);
    chk({tag, " jack_changed count"}, jc_cnt, exp_jc);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err after clear", 32'(err), 0);
  endtask

  initial begin
    led = '0;
    led[7:0] = 8'd100;
    led[15:8] = 8'h80;
    repeat (3) @(negedge clk);
    chk("reset stb", 32'(stb), 0);
    chk("reset cmd", 32'(cmd), 0);
    chk("reset data_in", 32'(data_in), 0);
    chk("reset ack_in", 32'(ack_in), 1);
    chk("reset jack", 32'(jack), 0);
    chk("reset jack_valid", 32'(jack_valid), 0);
    chk("reset jack_changed", 32'(jack_changed), 0);
    chk("reset err", 32'(err), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    jack_val = 8'h05;
    round(0, 1, "round1");
    round(0, 0, "round2");
    jack_val = 8'($urandom) | 8'h01;
    round(0, 0, "round3");
    nack_cnt = 1;
    round(1, 0, "nack once");
    clear_err();
    nack_cnt = MAXA;
    round(MAXA, 0, "nack persistent");
    clear_err();
    nack_cnt = 1;
    clr_with_nack = 1;
    round(1, 0, "nack with clear");
    clr_with_nack = 0;
    clear_err();
    wait_log(6, "mid reset");
    if (log_q.size() > 5) chk("mid reset 5th write", 32'(log_q[5].c), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset stb", 32'(stb), 0);
    chk("mid reset cmd", 32'(cmd), 0);
    chk("mid reset data_in", 32'(data_in), 0);
    chk("mid reset jack", 32'(jack), 0);
    log_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    prev_jack = '0;
    jack_val = 8'h00;
    round(0, 1, "after reset zero");
    jack_val = 8'h33;
    round(0, 0, "after reset");
    chk("protocol violations", proto, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
